// File: rtl/fork_stage.sv
// Eager two-way fork stage: one valid/stall input stream copied to two consumer streams.
// Define FORK_STAGE_SKID_EN to add a one-entry skid register and make stall_o registered.
module fork_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             stall_o,
  output logic             v_o1,
  output logic [WIDTH-1:0] data_o1,
  input  logic             stall_i1,
  output logic             v_o2,
  output logic [WIDTH-1:0] data_o2,
  input  logic             stall_i2
);

  // State is the pair of pending flags {pend1, pend2}.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ONLY2 = 2'b01;
  localparam logic [1:0] ONLY1 = 2'b10;
  localparam logic [1:0] BOTH  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       state_ret;
  logic [WIDTH-1:0] data_r;
  logic             pend1;
  logic             pend2;
  logic             drain;

  assign pend1 = state[1];
  assign pend2 = state[0];

  // The current item is retired once every consumer still owed it is not stalling.
  assign drain = (!pend1 || !stall_i1) && (!pend2 || !stall_i2);

  // Each flag survives only while its consumer keeps stalling.
  always_comb begin
    state_ret = IDLE;
    if (pend1 && stall_i1) state_ret = state_ret | ONLY1;
    if (pend2 && stall_i2) state_ret = state_ret | ONLY2;
  end

  assign v_o1    = pend1;
  assign v_o2    = pend2;
  assign data_o1 = data_r;
  assign data_o2 = data_r;

`ifdef FORK_STAGE_SKID_EN

  logic             skid_v;
  logic [WIDTH-1:0] skid_data;
  logic             take_in;

  // stall_o is a flop, so upstream never sees a combinational path from stall_i1/stall_i2.
  assign stall_o = skid_v;
  assign take_in = v_i && !skid_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data_r    <= '0;
      skid_v    <= 1'b0;
      skid_data <= '0;
    end else if (drain && skid_v) begin
      // The parked item has priority; upstream is held off this cycle by stall_o.
      data_r <= skid_data;
      state  <= BOTH;
      skid_v <= 1'b0;
    end else if (drain && v_i) begin
      data_r <= data_i;
      state  <= BOTH;
    end else begin
      state <= state_ret;
      if (take_in) begin
        skid_data <= data_i;
        skid_v    <= 1'b1;
      end
    end
  end

`else

  logic accept;

  assign stall_o = !drain;
  assign accept  = v_i && drain;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data_r <= '0;
    end else if (accept) begin
      // A retiring item and a new arrival in the same cycle go straight back to BOTH.
      data_r <= data_i;
      state  <= BOTH;
    end else begin
      state <= state_ret;
    end
  end

`endif

endmodule

// File: tb/tb_fork_stage.sv
// Self-checking bench for fork_stage: directed scenarios plus a queue scoreboard
// that follows every transfer on the input and both outputs.
module tb_fork_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             v_i;
  logic [WIDTH-1:0] data_i;
  logic             stall_o;
  logic             v_o1;
  logic [WIDTH-1:0] data_o1;
  logic             stall_i1;
  logic             v_o2;
  logic [WIDTH-1:0] data_o2;
  logic             stall_i2;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];
  logic             hold1 = 1'b0;
  logic             hold2 = 1'b0;
  logic [WIDTH-1:0] held1 = '0;
  logic [WIDTH-1:0] held2 = '0;

  fork_stage #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .v_i      (v_i),
    .data_i   (data_i),
    .stall_o  (stall_o),
    .v_o1     (v_o1),
    .data_o1  (data_o1),
    .stall_i1 (stall_i1),
    .v_o2     (v_o2),
    .data_o2  (data_o2),
    .stall_i2 (stall_i2)
  );

  always #5 clk = ~clk;

  // Scoreboard and stability monitor, sampled mid-cycle on the inputs the next edge will see.
  task automatic monitor();
    logic [WIDTH-1:0] exp;
    if (reset) begin
      q1.delete();
      q2.delete();
      hold1 = 1'b0;
      hold2 = 1'b0;
      return;
    end
    if (hold1) begin
      checks++;
      if (v_o1 !== 1'b1 || data_o1 !== held1) begin
        errors++;
        $display("FAIL stable_o1: got v=%b d=%h want v=1 d=%h", v_o1, data_o1, held1);
      end
    end
    if (hold2) begin
      checks++;
      if (v_o2 !== 1'b1 || data_o2 !== held2) begin
        errors++;
        $display("FAIL stable_o2: got v=%b d=%h want v=1 d=%h", v_o2, data_o2, held2);
      end
    end
    if (v_o1 === 1'b1 && stall_i1 === 1'b0) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb_o1: got unexpected item %h want none", data_o1);
      end else begin
        exp = q1.pop_front();
        if (data_o1 !== exp) begin
          errors++;
          $display("FAIL sb_o1: got %h want %h", data_o1, exp);
        end
      end
    end
    if (v_o2 === 1'b1 && stall_i2 === 1'b0) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL sb_o2: got unexpected item %h want none", data_o2);
      end else begin
        exp = q2.pop_front();
        if (data_o2 !== exp) begin
          errors++;
          $display("FAIL sb_o2: got %h want %h", data_o2, exp);
        end
      end
    end
    if (v_i === 1'b1 && stall_o === 1'b0) begin
      q1.push_back(data_i);
      q2.push_back(data_i);
    end
    hold1 = (v_o1 === 1'b1 && stall_i1 === 1'b1);
    hold2 = (v_o2 === 1'b1 && stall_i2 === 1'b1);
    held1 = data_o1;
    held2 = data_o2;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s1, input logic s2);
    v_i      = v;
    data_i   = d;
    stall_i1 = s1;
    stall_i2 = s2;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (v_o1 !== 1'b0 || v_o2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got v1=%b v2=%b want 0 0", v_o1, v_o2);
    end
    checks++;
    if (data_o1 !== '0 || data_o2 !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h want 0 0", data_o1, data_o2);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", stall_o);
    end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] vals[3];
    vals = '{32'd1, 32'd2, 32'd3};
    drive(1'b1, vals[0], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stall_o !== 1'b0) begin
        errors++;
        $display("FAIL stream_stall[%0d]: got %b want 0", i, stall_o);
      end
      if (i > 0) begin
        checks++;
        if (v_o1 !== 1'b1 || v_o2 !== 1'b1 || data_o1 !== vals[i-1] || data_o2 !== vals[i-1]) begin
          errors++;
          $display("FAIL stream_out[%0d]: got v=%b%b d=%h/%h want v=11 d=%h",
                   i, v_o1, v_o2, data_o1, data_o2, vals[i-1]);
        end
      end
      tick();
      if (i < 2) drive(1'b1, vals[i+1], 1'b0, 1'b0);
      else       drive(1'b0, '0, 1'b0, 1'b0);
    end
    checks++;
    if (v_o1 !== 1'b0 || v_o2 !== 1'b0) begin
      errors++;
      $display("FAIL stream_idle: got v=%b%b want 00", v_o1, v_o2);
    end
  endtask

  task automatic test_asymmetric_stall();
    drive(1'b1, 32'hF, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (v_o1 !== 1'b1 || v_o2 !== 1'b1 || data_o1 !== 32'hF || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL asym_both: got v=%b%b d=%h stall=%b want v=11 d=f stall=1",
               v_o1, v_o2, data_o1, stall_o);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'd100, 1'b0, 1'b1);
      checks++;
      if (v_o1 !== 1'b0 || v_o2 !== 1'b1 || data_o2 !== 32'hF || stall_o !== 1'b1) begin
        errors++;
        $display("FAIL asym_only2[%0d]: got v=%b%b d2=%h stall=%b want v=01 d2=f stall=1",
                 i, v_o1, v_o2, data_o2, stall_o);
      end
      tick();
    end
    drive(1'b1, 32'd100, 1'b0, 1'b0);
    checks++;
    if (v_o2 !== 1'b1 || data_o2 !== 32'hF || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL asym_release: got v2=%b d2=%h stall=%b want v2=1 d2=f stall=0",
               v_o2, data_o2, stall_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (v_o1 !== 1'b1 || v_o2 !== 1'b1 || data_o1 !== 32'd100 || data_o2 !== 32'd100) begin
      errors++;
      $display("FAIL asym_next: got v=%b%b d=%h/%h want v=11 d=64", v_o1, v_o2, data_o1, data_o2);
    end
    tick();
  endtask

  task automatic test_drain_refill();
    drive(1'b1, 32'd200, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'd10, 1'b0, 1'b0);
    checks++;
    if (v_o1 !== 1'b1 || v_o2 !== 1'b0 || data_o1 !== 32'd200 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL refill_only1: got v=%b%b d1=%h stall=%b want v=10 d1=c8 stall=0",
               v_o1, v_o2, data_o1, stall_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (v_o1 !== 1'b1 || v_o2 !== 1'b1 || data_o1 !== 32'd10 || data_o2 !== 32'd10) begin
      errors++;
      $display("FAIL refill_both: got v=%b%b d=%h/%h want v=11 d=a", v_o1, v_o2, data_o1, data_o2);
    end
    tick();
  endtask

  task automatic test_both_stalled();
    drive(1'b1, 32'd1000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd555, 1'b1, 1'b1);
      checks++;
      if (v_o1 !== 1'b1 || v_o2 !== 1'b1 || data_o1 !== 32'd1000 || data_o2 !== 32'd1000
          || stall_o !== 1'b1) begin
        errors++;
        $display("FAIL both_hold[%0d]: got v=%b%b d=%h/%h stall=%b want v=11 d=3e8 stall=1",
                 i, v_o1, v_o2, data_o1, data_o2, stall_o);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    checks++;
    if (v_o1 !== 1'b0 || v_o2 !== 1'b0) begin
      errors++;
      $display("FAIL both_release: got v=%b%b want 00", v_o1, v_o2);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'd77, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (v_o1 !== 1'b0 || v_o2 !== 1'b0 || data_o1 !== '0 || data_o2 !== '0 || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got v=%b%b d=%h/%h stall=%b want v=00 d=0 stall=0",
                 i, v_o1, v_o2, data_o1, data_o2, stall_o);
      end
      tick();
    end
  endtask

`ifdef FORK_STAGE_SKID_EN
  task automatic test_skid();
    drive(1'b1, 32'd5, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL skid_idle_stall: got %b want 0", stall_o);
    end
    tick();
    drive(1'b1, 32'd6, 1'b1, 1'b0);
    checks++;
    if (v_o1 !== 1'b1 || data_o1 !== 32'd5 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL skid_first: got v1=%b d1=%h stall=%b want v1=1 d1=5 stall=0",
               v_o1, data_o1, stall_o);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b1 || v_o1 !== 1'b1 || v_o2 !== 1'b0 || data_o1 !== 32'd5) begin
      errors++;
      $display("FAIL skid_full: got stall=%b v=%b%b d1=%h want stall=1 v=10 d1=5",
               stall_o, v_o1, v_o2, data_o1);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (stall_o !== 1'b1 || data_o1 !== 32'd5) begin
      errors++;
      $display("FAIL skid_release: got stall=%b d1=%h want stall=1 d1=5", stall_o, data_o1);
    end
    tick();
    checks++;
    if (stall_o !== 1'b0 || v_o1 !== 1'b1 || v_o2 !== 1'b1 || data_o1 !== 32'd6 || data_o2 !== 32'd6) begin
      errors++;
      $display("FAIL skid_second: got stall=%b v=%b%b d=%h/%h want stall=0 v=11 d=6",
               stall_o, v_o1, v_o2, data_o1, data_o2);
    end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL b2b_drained: got %0d/%0d items outstanding want 0/0", q1.size(), q2.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    v_i      = 1'b0;
    data_i   = '0;
    stall_i1 = 1'b0;
    stall_i2 = 1'b0;
    test_reset();
    test_streaming();
`ifdef FORK_STAGE_SKID_EN
    test_skid();
`else
    test_asymmetric_stall();
    test_drain_refill();
    test_both_stalled();
`endif
    test_reset_mid();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
